// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: round-robin arbiter/sequencer sharing one registered binary-to-BCD converter between two requesters.
// Optional result cache enabled by defining BCD_CONV_CACHE_EN.
`default_nettype none

module bcd_conv_arb #(
  parameter int   CONV_LAT = 1,
  parameter logic RR_INIT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [11:0] rsp_bcd,
  input  logic        rsp_ready,
  output logic        cv_en,
  output logic [7:0]  cv_a,
  input  logic [11:0] cv_b,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(CONV_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  opnd_q, opnd_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [11:0] bcd_q, bcd_d;

  logic        gnt_vld;
  logic        gnt;
  logic [7:0]  sel;

`ifdef BCD_CONV_CACHE_EN
  logic        cache_vld_q, cache_vld_d;
  logic [7:0]  cache_a_q, cache_a_d;
  logic [11:0] cache_bcd_q, cache_bcd_d;
`endif

  // On contention the requester that did not win last time is served.
  assign gnt_vld = |req_valid;
  assign gnt     = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign sel     = gnt ? req_data[15:8] : req_data[7:0];

  assign req_ready = (state_q == S_IDLE && gnt_vld && !rst) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_bcd   = bcd_q;
  assign cv_en     = (state_q == S_LOAD);
  assign cv_a      = opnd_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    last_d  = last_q;
    id_d    = id_q;
    bcd_d   = bcd_q;
`ifdef BCD_CONV_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_a_d   = cache_a_q;
    cache_bcd_d = cache_bcd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          opnd_d  = sel;
          id_d    = gnt;
          last_d  = gnt;
          state_d = S_LOAD;
`ifdef BCD_CONV_CACHE_EN
          if (cache_vld_q && (cache_a_q == sel)) begin
            bcd_d   = cache_bcd_q;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_LOAD: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          bcd_d   = cv_b;
          state_d = S_RESP;
`ifdef BCD_CONV_CACHE_EN
          cache_vld_d = 1'b1;
          cache_a_d   = opnd_q;
          cache_bcd_d = cv_b;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      opnd_q  <= 8'd0;
      last_q  <= RR_INIT;
      id_q    <= 1'b0;
      bcd_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      last_q  <= last_d;
      id_q    <= id_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef BCD_CONV_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_a_q   <= 8'd0;
      cache_bcd_q <= 12'd0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_a_q   <= cache_a_d;
      cache_bcd_q <= cache_bcd_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arb.sv
// tb_bcd_conv_arb: directed bench with a cycle-timed reference model and a behavioural converter.
`default_nettype none

module tb_bcd_conv_arb;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [11:0] rsp_bcd;
  logic        rsp_ready;
  logic        cv_en;
  logic [7:0]  cv_a;
  logic [11:0] cv_b = '0;
  logic        busy;

  always #5 clk = ~clk;

  bcd_conv_arb #(.CONV_LAT(LAT), .RR_INIT(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_bcd(rsp_bcd), .rsp_ready(rsp_ready), .cv_en(cv_en), .cv_a(cv_a),
    .cv_b(cv_b), .busy(busy)
  );

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int n;
    n = int'(v);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Converter model with one cycle of latency.
  always @(posedge clk) if (cv_en) cv_b <= to_bcd(cv_a);

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [1:0]  acc_pend = 2'b00;
  logic [12:0] rlog[$];
  int          llog[$];
  int          en_cnt = 0;

  // Source driver: each requester presents the head of its queue until accepted.
  initial begin
    req_valid = 2'b00;
    req_data  = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_pend[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc_pend[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid  = {q1.size() > 0, q0.size() > 0};
      req_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
      req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // Reference model: tracks one transaction by its accept cycle.
  logic       m_idle = 1'b1;
  logic       m_last = 1'b1;
  logic       m_id, m_hit, g, rv;
  logic [7:0] m_op;
  logic [11:0] m_bcd;
  logic [1:0] exp_r;
  logic       m_cvld = 1'b0;
  logic [7:0] m_ca = 8'h00;
  int         m_acc, m_due;

  always @(negedge clk) begin
    acc_pend = req_valid & req_ready;
    if (cv_en) en_cnt++;
    if (rst) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_bcd, cv_en, cv_a, busy}, 32'h0);
      m_idle = 1'b1;
      m_last = 1'b1;
      m_cvld = 1'b0;
    end else if (m_idle) begin
      g     = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_r = (|req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready_idle", req_ready, exp_r);
      chk("idle_busy_rv_en", {busy, rsp_valid, cv_en}, 32'h0);
      if (|req_valid) begin
        m_idle = 1'b0;
        m_acc  = cyc;
        m_id   = g;
        m_op   = g ? req_data[15:8] : req_data[7:0];
        m_bcd  = to_bcd(m_op);
        m_last = g;
`ifdef BCD_CONV_CACHE_EN
        m_hit  = m_cvld && (m_ca == m_op);
`else
        m_hit  = 1'b0;
`endif
        m_due  = m_acc + (m_hit ? 1 : 2 + LAT);
      end
    end else begin
      chk("req_ready_busy", req_ready, 32'h0);
      chk("busy", busy, 32'h1);
      chk("cv_en", cv_en, (!m_hit && cyc == m_acc + 1) ? 32'h1 : 32'h0);
      chk("cv_a", cv_a, m_op);
      rv = (cyc >= m_due);
      chk("rsp_valid", rsp_valid, rv);
      if (rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_bcd", rsp_bcd, m_bcd);
        if (cyc == m_due) begin
          llog.push_back(cyc - m_acc);
          if (!m_hit) begin
            m_cvld = 1'b1;
            m_ca   = m_op;
          end
        end
        if (rsp_ready) begin
          rlog.push_back({rsp_id, rsp_bcd});
          m_idle = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #3;
    while ((q0.size() > 0 || q1.size() > 0 || busy || rsp_valid) && n < 300) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= 300) chk("wait_idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [12:0] exp);
    if (idx < rlog.size()) chk(name, rlog[idx], exp);
    else chk(name, 32'hdead, exp);
  endtask

  task automatic check_lat(input string name, input int idx, input int exp);
    if (idx < llog.size()) chk(name, llog[idx], exp);
    else chk(name, 32'hdead, exp);
  endtask

  initial begin
    int b, n, e0;
    logic [7:0]  v0[4];
    logic [7:0]  v1[4];
    logic [11:0] e_lo[4];
    logic [11:0] e_hi[4];
    v0 = '{8'd1, 8'd2, 8'd3, 8'd4};
    v1 = '{8'd10, 8'd20, 8'd30, 8'd40};
    e_lo = '{12'h001, 12'h002, 12'h003, 12'h004};
    e_hi = '{12'h010, 12'h020, 12'h030, 12'h040};
    rst = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request, maximum operand.
    b = rlog.size();
    @(posedge clk); #2 q0.push_back(8'd255);
    wait_idle();
    check_log("t1_rsp", b, {1'b0, 12'h255});
    check_lat("t1_latency", b, 3);

    // Simultaneous requests after reset: requester 0 first.
    do_reset();
    b = rlog.size();
    @(posedge clk); #2 q0.push_back(8'd99); q1.push_back(8'd0);
    wait_idle();
    check_log("t2_first", b, {1'b0, 12'h099});
    check_log("t2_second", b + 1, {1'b1, 12'h000});

    // Continuous contention alternates grants.
    do_reset();
    b = rlog.size();
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(v0[i]);
      q1.push_back(v1[i]);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      check_log("t3_req0", b + 2 * i, {1'b0, e_lo[i]});
      check_log("t3_req1", b + 2 * i + 1, {1'b1, e_hi[i]});
    end

    // Backpressure on the response; a competing request waits.
    b = rlog.size();
    @(posedge clk); #2 rsp_ready = 1'b0; q0.push_back(8'd128);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 50) chk("t4_rsp_timeout", 32'h1, 32'h0);
    q1.push_back(8'd7);
    repeat (5) @(posedge clk);
    #2;
    chk("t4_held_no_rsp", rlog.size() - b, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #3;
    chk("t4_one_rsp", rlog.size() - b, 32'h1);
    wait_idle();
    check_log("t4_rsp", b, {1'b0, 12'h128});
    check_log("t4_next", b + 1, {1'b1, 12'h007});

    // Reset while waiting on the converter abandons the request.
    b = rlog.size();
    @(posedge clk); #2 q0.push_back(8'd77);
    n = 0;
    while (!cv_en && n < 50) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 50) chk("t5_load_timeout", 32'h1, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("t5_rst_outputs", {req_ready, rsp_valid, rsp_id, rsp_bcd, cv_en, cv_a, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_no_rsp_77", rlog.size() - b, 32'h0);
    @(posedge clk); #2 q0.push_back(8'd5);
    wait_idle();
    chk("t5_count", rlog.size() - b, 32'h1);
    check_log("t5_rsp", b, {1'b0, 12'h005});

    // Same operand twice: cache hit when enabled.
    do_reset();
    b  = rlog.size();
    e0 = en_cnt;
    @(posedge clk); #2 q0.push_back(8'd200);
    wait_idle();
    @(posedge clk); #2 q0.push_back(8'd200);
    wait_idle();
    check_log("t6_first", b, {1'b0, 12'h200});
    check_log("t6_second", b + 1, {1'b0, 12'h200});
    check_lat("t6_lat_first", b, 3);
`ifdef BCD_CONV_CACHE_EN
    check_lat("t6_lat_second", b + 1, 1);
    chk("t6_cv_en_pulses", en_cnt - e0, 32'd1);
`else
    check_lat("t6_lat_second", b + 1, 3);
    chk("t6_cv_en_pulses", en_cnt - e0, 32'd2);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
